// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory pipe.
// Holds the FSM state enum and the fault bit layout.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  localparam logic [31:0] FAULT_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_array.sv
// Byte storage with a byte-enabled load port and a combinational
// little-endian word read.
// Ports: clk; ld_en/ld_addr/ld_data/ld_be load write;
// rd_addr in, rd_data/rd_misalign/rd_range out.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic [3:0]        ld_be,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic              rd_misalign,
  output logic              rd_range
);

  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam logic [ADDR_W:0] LAST =
    (ADDR_W + 1)'(MEM_BYTES - 4);

  if (ADDR_W < IDX_W || ADDR_W < 2) begin : g_aw_chk
    $error("ADDR_W too narrow for MEM_BYTES");
  end

  logic [7:0] mem_q [MEM_BYTES];

  logic [ADDR_W-1:0] wr_word;
  logic              wr_ok;
  logic [IDX_W-1:0]  wr_base;
  logic [IDX_W-1:0]  rd_base;

  assign wr_word = ld_addr & ~ADDR_W'(3);
  assign wr_ok   = {1'b0, wr_word} <= LAST;
  assign wr_base = ld_addr[IDX_W-1:0] & ~IDX_W'(3);

  // Out-of-range reads are forced to faulting zero upstream;
  // clamping the index keeps every array access in bounds.
  assign rd_range    = {1'b0, rd_addr} > LAST;
  assign rd_misalign = rd_addr[1:0] != 2'b00;
  assign rd_base     = rd_range ? '0 : rd_addr[IDX_W-1:0];

  assign rd_data = {
    mem_q[rd_base + IDX_W'(3)],
    mem_q[rd_base + IDX_W'(2)],
    mem_q[rd_base + IDX_W'(1)],
    mem_q[rd_base]
  };

  always_ff @(posedge clk) begin
    if (ld_en && wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (ld_be[i]) begin
          mem_q[wr_base + IDX_W'(i)] <= ld_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/instr_mem_pipe.sv
// Fetch-side instruction memory with wait states, faults and flush.
// Ports: clk, rst_n; req_* request; rsp_* response; flush; ld_* load.
module instr_mem_pipe
  import instr_mem_pkg::*;
#(
  parameter int MEM_BYTES   = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [1:0]        rsp_fault,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic [3:0]        ld_be
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_chk
    $error("WAIT_STATES must be within 0..15");
  end

  if (MEM_BYTES < 4 || (MEM_BYTES % 4) != 0) begin : g_mb_chk
    $error("MEM_BYTES must be a multiple of 4, >= 4");
  end

  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       instr_q, instr_d;
  logic [1:0]        fault_q, fault_d;

  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_misalign;
  logic              rd_range;
  logic [1:0]        rd_fault;

  logic accept;
  logic go_flush, go_start, go_load, go_dec, go_done;

  // Zero wait states read on the accept edge itself, so the
  // live request address feeds the array outside WAIT.
  assign rd_addr = (state_q == WAIT) ? addr_q : req_addr;

  instr_mem_array #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_array (
    .clk         (clk),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_be       (ld_be),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_misalign (rd_misalign),
    .rd_range    (rd_range)
  );

  assign rd_fault[FAULT_MISALIGN] = rd_misalign;
  assign rd_fault[FAULT_RANGE]    = rd_range;

  assign rsp_valid = (state_q == RESP);
  assign rsp_instr = instr_q;
  assign rsp_fault = fault_q;

  assign req_ready = !flush && !ld_en &&
    (state_q == IDLE || (state_q == RESP && rsp_ready));

  assign accept = req_valid && req_ready;

  // Mutually exclusive events; flush outranks everything.
  assign go_flush = flush;
  assign go_start = accept;
  assign go_load  = !flush && state_q == WAIT && cnt_q == 4'd0;
  assign go_dec   = !flush && state_q == WAIT && cnt_q != 4'd0;
  assign go_done  = !flush && !accept &&
    state_q == RESP && rsp_ready;

  always_comb begin
    logic capture;
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    fault_d = fault_q;
    capture = 1'b0;
    unique case (1'b1)
      go_flush: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      go_start: begin
        addr_d = req_addr;
        if (WAIT_STATES == 0) begin
          state_d = RESP;
          capture = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      go_load: begin
        state_d = RESP;
        capture = 1'b1;
      end
      go_dec: begin
        cnt_d = cnt_q - 4'd1;
      end
      go_done: begin
        state_d = IDLE;
      end
      default: ;
    endcase
    if (capture) begin
      fault_d = rd_fault;
      instr_d = (|rd_fault) ? FAULT_INSTR : rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      instr_q <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Scoreboard bench: two instances (0 and 3 wait states) share the
// load port; requests push expectations, a monitor checks each cycle.
module tb_instr_mem_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  fault;
    longint      due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_instr [2];
  logic [1:0]  rsp_fault [2];
  logic        flush     [2];
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  ld_be;

  exp_t        sb [2][$];
  logic [31:0] last_instr [2];
  logic [1:0]  last_fault [2];
  logic [7:0]  mem_m [256];
  longint      cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          rand_rdy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_mem_pipe #(
    .MEM_BYTES(256), .ADDR_W(32), .WAIT_STATES(0)
  ) u_ws0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_instr(rsp_instr[0]), .rsp_fault(rsp_fault[0]),
    .flush(flush[0]),
    .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_be(ld_be)
  );

  instr_mem_pipe #(
    .MEM_BYTES(256), .ADDR_W(32), .WAIT_STATES(3)
  ) u_ws3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_instr(rsp_instr[1]), .rsp_fault(rsp_fault[1]),
    .flush(flush[1]),
    .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_be(ld_be)
  );

  function automatic int ws(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed little-endian read of a 256-byte store.
  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    logic [63:0] u;
    u = {32'b0, a};
    e.fault[0] = (a % 4) != 0;
    e.fault[1] = (u + 64'd4) > 64'd256;
    e.instr = 32'h0;
    e.due = 0;
    if (e.fault == 2'b00) begin
      for (int i = 0; i < 4; i++)
        e.instr[8*i +: 8] = mem_m[int'(a) + i];
    end
    return e;
  endfunction

  task automatic model_load(input logic [31:0] a,
                            input logic [31:0] d,
                            input logic [3:0] be);
    logic [31:0] wa;
    wa = (a / 4) * 4;
    if (({32'b0, wa} + 64'd4) <= 64'd256) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_m[int'(wa) + i] = d[8*i +: 8];
    end
  endtask

  task automatic rnd_ctl();
    for (int k = 0; k < 2; k++) begin
      rsp_ready[k] = 1'($urandom_range(0, 1));
      flush[k] = ($urandom_range(0, 31) == 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_rdy) rnd_ctl();
    end
  endtask

  // Called at a falling edge; returns one falling edge after accept.
  task automatic load(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    ld_en = 1'b1; ld_addr = a; ld_data = d; ld_be = be;
    model_load(a, d, be);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic req(input int k, input logic [31:0] a,
                     output int w);
    exp_t e;
    w = 0;
    if (rand_rdy) rnd_ctl();
    req_valid[k] = 1'b1;
    req_addr[k] = a;
    #1;
    while (!req_ready[k] && w < 50) begin
      @(negedge clk);
      if (rand_rdy) rnd_ctl();
      #1;
      w++;
    end
    chk($sformatf("req_accept%0d", k), 32'(req_ready[k]), 32'd1);
    if (req_ready[k]) begin
      e = model(a);
      e.due = cyc + 1 + ws(k);
      sb[k].push_back(e);
    end
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 3))
      0, 1: return 32'($urandom_range(0, 63)) * 4;
      2: return 32'($urandom_range(0, 255));
      default: begin
        if ($urandom_range(0, 1) == 1)
          return 32'h100 + 32'($urandom_range(0, 15));
        return $urandom;
      end
    endcase
  endfunction

  initial begin : monitor
    bit ev;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          sb[k].delete();
          last_instr[k] = 32'h0;
          last_fault[k] = 2'b00;
          chk($sformatf("reset_valid%0d", k),
              32'(rsp_valid[k]), 32'd0);
          chk($sformatf("reset_instr%0d", k), rsp_instr[k], 32'h0);
          chk($sformatf("reset_fault%0d", k),
              32'(rsp_fault[k]), 32'd0);
        end else begin
          ev = sb[k].size() > 0 && cyc >= sb[k][0].due;
          if (ev) begin
            last_instr[k] = sb[k][0].instr;
            last_fault[k] = sb[k][0].fault;
          end
          chk($sformatf("rsp_valid%0d", k),
              32'(rsp_valid[k]), 32'(ev));
          chk($sformatf("rsp_instr%0d", k),
              rsp_instr[k], last_instr[k]);
          chk($sformatf("rsp_fault%0d", k),
              32'(rsp_fault[k]), 32'(last_fault[k]));
          if (flush[k]) sb[k].delete();
          else if (ev && rsp_ready[k]) void'(sb[k].pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w;
    int n;
    rst_n = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_be = '0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0;
      rsp_ready[k] = 1'b0; flush[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) load(32'(i * 4), $urandom, 4'hF);

    // Zero wait states: single fetch then back-to-back.
    load(32'h10, 32'h0050_0093, 4'hF);
    rsp_ready[0] = 1'b1;
    req(0, 32'h10, w);
    chk("ws0_first_wait", 32'(w), 32'd0);
    req(0, 32'h10, w);
    req(0, 32'h14, w);
    chk("b2b_wait", 32'(w), 32'd0);
    idle(3);

    // Three wait states: ready held low while counting.
    rsp_ready[1] = 1'b1;
    req(1, 32'h0, w);
    for (int i = 0; i < 3; i++) begin
      #1 chk("wait_ready", 32'(req_ready[1]), 32'd0);
      @(negedge clk);
    end
    idle(3);

    // Backpressure in RESP.
    rsp_ready[0] = 1'b0;
    req(0, 32'h10, w);
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    #1 chk("bp_idle_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);

    // Fault corners.
    rsp_ready[0] = 1'b1;
    req(0, 32'h06, w);
    req(0, 32'hFC, w);
    req(0, 32'h100, w);
    req(0, 32'h102, w);
    idle(2);

    // Byte enables; the waited read lands on the load edge.
    load(32'h40, 32'h1122_3344, 4'hF);
    req(1, 32'h40, w);
    idle(2);
    load(32'h40, 32'hAABB_CCDD, 4'b0101);
    idle(2);
    req(0, 32'h40, w);
    load(32'h100, 32'hDEAD_BEEF, 4'hF);
    load(32'h43, 32'h5566_7788, 4'b1000);
    req(0, 32'h0, w);
    req(0, 32'h40, w);
    idle(5);

    // Flush during WAIT with a competing request.
    req(1, 32'h8, w);
    flush[1] = 1'b1;
    req_valid[1] = 1'b1;
    req_addr[1] = 32'h4;
    #1 chk("flush_wait_ready", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    flush[1] = 1'b0;
    req_valid[1] = 1'b0;
    #1 chk("post_flush_ready", 32'(req_ready[1]), 32'd1);
    idle(6);

    // Flush in RESP beats the handshake.
    rsp_ready[0] = 1'b0;
    req(0, 32'h14, w);
    flush[0] = 1'b1;
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    #1 chk("flush_resp_ready", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    flush[0] = 1'b0;
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b0;
    idle(3);

    // Asynchronous reset mid-WAIT.
    rsp_ready[1] = 1'b1;
    req(1, 32'h20, w);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(rsp_valid[1]), 32'd0);
    chk("rst_async_instr", rsp_instr[1], 32'h0);
    chk("rst_async_fault", 32'(rsp_fault[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);

    // Randomised traffic.
    rand_rdy = 1'b1;
    repeat (300) begin
      if (sb[0].size() == 0 && sb[1].size() == 0 &&
          $urandom_range(0, 7) == 0) begin
        load($urandom_range(0, 300), $urandom,
             4'($urandom_range(0, 15)));
      end else begin
        req(int'($urandom_range(0, 1)), rnd_addr(), w);
      end
      idle(int'($urandom_range(0, 2)));
    end

    rand_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      flush[k] = 1'b0;
      rsp_ready[k] = 1'b1;
    end
    n = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb[0].size() + sb[1].size()), 32'd0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
